// File: rtl/tea_wb_pkg.sv
// Shared types and default address map for the TEA Wishbone master.
// Imported by tea_wb_master and wb_single_xfer.
package tea_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_POLL,
        ST_READ,
        ST_DONE,
        ST_ERR
    } state_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_ACT,
        X_GAP
    } xfer_state_t;

    localparam logic [7:0]  DEF_ADR_REGA   = 8'h00;
    localparam logic [7:0]  DEF_ADR_REGB   = 8'h04;
    localparam logic [7:0]  DEF_ADR_KEY0   = 8'h08;
    localparam logic [7:0]  DEF_ADR_STATUS = 8'h18;
    localparam logic [7:0]  DEF_ADR_RES_E0 = 8'h1C;
    localparam logic [7:0]  DEF_ADR_RES_D0 = 8'h24;
    localparam int unsigned DEF_POLL_MAX   = 1024;

    localparam int unsigned STAT_DONE_ENC  = 0;
    localparam int unsigned STAT_DONE_DEC  = 1;

    localparam int unsigned N_WRITES       = 6;

endpackage

// File: rtl/wb_single_xfer.sv
// One Wishbone classic single transfer with registered strobes.
// Termination is reported combinationally so the caller can update adr/dat during the gap cycle.
module wb_single_xfer
    import tea_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  adr,
    input  logic [31:0] wdat,
    output logic        ack,
    output logic        err,
    output logic        rty,
    output logic [31:0] rdat,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [7:0]  wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i
);

    xfer_state_t st;
    logic        term;

    // err has priority over rty, rty over ack, so exactly one result fires
    assign err  = wb_stb_o && wb_err_i;
    assign rty  = wb_stb_o && wb_rty_i && !wb_err_i;
    assign ack  = wb_stb_o && wb_ack_i && !wb_err_i && !wb_rty_i;
    assign term = wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i);
    assign rdat = wb_dat_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= X_IDLE;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
        end else begin
            case (st)
                X_IDLE, X_GAP: begin
                    if (req) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= we;
                        wb_adr_o <= adr;
                        wb_dat_o <= wdat;
                        st       <= X_ACT;
                    end else begin
                        st       <= X_IDLE;
                    end
                end
                X_ACT: begin
                    if (term) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_we_o  <= 1'b0;
                        st       <= X_GAP;
                    end
                end
                default: st <= X_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tea_wb_master.sv
// Drives a memory-mapped TEA core over Wishbone: load key/operand, poll status, fetch result.
// wb_rst_i is active-low; it asserts asynchronously and is released through a 2-flop synchronizer.
module tea_wb_master
    import tea_wb_pkg::*;
#(
    parameter logic [7:0]  ADR_KEY0   = DEF_ADR_KEY0,
    parameter logic [7:0]  ADR_REGA   = DEF_ADR_REGA,
    parameter logic [7:0]  ADR_REGB   = DEF_ADR_REGB,
    parameter logic [7:0]  ADR_STATUS = DEF_ADR_STATUS,
    parameter logic [7:0]  ADR_RES_E0 = DEF_ADR_RES_E0,
    parameter logic [7:0]  ADR_RES_D0 = DEF_ADR_RES_D0,
    parameter int unsigned POLL_MAX   = DEF_POLL_MAX
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         start_i,
    input  logic         mode_i,
    input  logic [127:0] key_i,
    input  logic [63:0]  data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [63:0]  result_o,
    output logic         err_o,
    output logic         wb_cyc_o,
    output logic         wb_stb_o,
    output logic         wb_we_o,
    output logic [7:0]   wb_adr_o,
    output logic [31:0]  wb_dat_o,
    output logic [3:0]   wb_sel_o,
    output logic [2:0]   wb_cti_o,
    output logic [1:0]   wb_bte_o,
    input  logic [31:0]  wb_dat_i,
    input  logic         wb_ack_i,
    input  logic         wb_err_i,
    input  logic         wb_rty_i
);

    localparam int unsigned    PCW       = $clog2(POLL_MAX + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);
    localparam logic [2:0]     LAST_WR   = 3'(N_WRITES - 1);

    logic [1:0]     rst_sync;
    logic           rst_n;

    state_t         state;
    logic [2:0]     idx;
    logic [PCW-1:0] poll_cnt;
    logic [127:0]   key_q;
    logic [63:0]    data_q;
    logic           mode_q;
    logic [31:0]    res_lo;
    logic           err_flag;

    logic           x_req, x_we, x_ack, x_err, x_rty, done_bit;
    logic [7:0]     x_adr;
    logic [31:0]    x_wdat, x_rdat;

    assign wb_sel_o = 4'hF;
    assign wb_cti_o = 3'b000;
    assign wb_bte_o = 2'b00;

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) rst_sync <= '0;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign x_req    = (state == ST_WRITE) || (state == ST_POLL) || (state == ST_READ);
    assign x_we     = (state == ST_WRITE);
    assign done_bit = mode_q ? x_rdat[STAT_DONE_DEC] : x_rdat[STAT_DONE_ENC];

    always_comb begin
        x_adr  = '0;
        x_wdat = '0;
        case (state)
            ST_WRITE: begin
                case (idx)
                    3'd0:    begin x_adr = ADR_KEY0;         x_wdat = key_q[31:0];    end
                    3'd1:    begin x_adr = ADR_KEY0 + 8'd4;  x_wdat = key_q[63:32];   end
                    3'd2:    begin x_adr = ADR_KEY0 + 8'd8;  x_wdat = key_q[95:64];   end
                    3'd3:    begin x_adr = ADR_KEY0 + 8'd12; x_wdat = key_q[127:96];  end
                    3'd4:    begin x_adr = ADR_REGA;         x_wdat = data_q[31:0];   end
                    default: begin x_adr = ADR_REGB;         x_wdat = data_q[63:32];  end
                endcase
            end
            ST_POLL: x_adr = ADR_STATUS;
            ST_READ: x_adr = (mode_q ? ADR_RES_D0 : ADR_RES_E0) + (idx[0] ? 8'd4 : 8'd0);
            default: ;
        endcase
    end

    wb_single_xfer u_xfer (
        .clk      (wb_clk_i),
        .rst_n    (rst_n),
        .req      (x_req),
        .we       (x_we),
        .adr      (x_adr),
        .wdat     (x_wdat),
        .ack      (x_ack),
        .err      (x_err),
        .rty      (x_rty),
        .rdat     (x_rdat),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i)
    );

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            poll_cnt <= '0;
            key_q    <= '0;
            data_q   <= '0;
            mode_q   <= 1'b0;
            res_lo   <= '0;
            err_flag <= 1'b0;
            result_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        key_q    <= key_i;
                        data_q   <= data_i;
                        mode_q   <= mode_i;
                        idx      <= '0;
                        poll_cnt <= '0;
                        err_flag <= 1'b0;
                        busy_o   <= 1'b1;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (x_err) begin
                        state <= ST_ERR;
                    end else if (x_rty) begin
                        idx   <= idx;
                    end else if (x_ack) begin
                        if (idx == LAST_WR) begin
                            idx   <= '0;
                            state <= ST_POLL;
                        end else begin
                            idx   <= idx + 3'd1;
                        end
                    end
                end
                ST_POLL: begin
                    if (x_err) begin
                        state <= ST_ERR;
                    end else if (x_ack) begin
                        poll_cnt <= poll_cnt + 1'b1;
                        if (done_bit) begin
                            idx   <= '0;
                            state <= ST_READ;
                        end else if (poll_cnt == POLL_LAST) begin
                            state <= ST_ERR;
                        end
                    end
                end
                ST_READ: begin
                    // word 0 is staged so an error on word 1 leaves result_o untouched
                    if (x_err) begin
                        state <= ST_ERR;
                    end else if (x_ack) begin
                        if (idx == 3'd0) begin
                            res_lo <= x_rdat;
                            idx    <= 3'd1;
                        end else begin
                            result_o <= {x_rdat, res_lo};
                            state    <= ST_DONE;
                        end
                    end
                end
                ST_ERR: begin
                    err_flag <= 1'b1;
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    done_o <= 1'b1;
                    err_o  <= err_flag;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tea_wb_master.sv
// Directed bench for tea_wb_master with a zero-wait Wishbone slave BFM and fault injection.
module tb_tea_wb_master;

    logic         clk = 1'b0;
    logic         wb_rst_i;
    logic         start_i, mode_i;
    logic [127:0] key_i;
    logic [63:0]  data_i;
    logic         busy_o, done_o, err_o;
    logic [63:0]  result_o;
    logic         wb_cyc_o, wb_stb_o, wb_we_o;
    logic [7:0]   wb_adr_o;
    logic [31:0]  wb_dat_o, wb_dat_i;
    logic [3:0]   wb_sel_o;
    logic [2:0]   wb_cti_o;
    logic [1:0]   wb_bte_o;
    logic         wb_ack_i, wb_err_i, wb_rty_i;

    logic         p4_start;
    logic         p4_busy, p4_done, p4_err;
    logic [63:0]  p4_result;
    logic         p4_cyc, p4_stb, p4_we;
    logic [7:0]   p4_adr;
    logic [31:0]  p4_dat_o, p4_dat_i;
    logic [3:0]   p4_sel;
    logic [2:0]   p4_cti;
    logic [1:0]   p4_bte;
    logic         p4_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tea_wb_master dut (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(start_i), .mode_i(mode_i),
        .key_i(key_i), .data_i(data_i), .busy_o(busy_o), .done_o(done_o),
        .result_o(result_o), .err_o(err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
    );

    tea_wb_master #(.POLL_MAX(4)) dut_p4 (
        .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .start_i(p4_start), .mode_i(1'b0),
        .key_i('0), .data_i('0), .busy_o(p4_busy), .done_o(p4_done),
        .result_o(p4_result), .err_o(p4_err), .wb_cyc_o(p4_cyc), .wb_stb_o(p4_stb),
        .wb_we_o(p4_we), .wb_adr_o(p4_adr), .wb_dat_o(p4_dat_o), .wb_sel_o(p4_sel),
        .wb_cti_o(p4_cti), .wb_bte_o(p4_bte), .wb_dat_i(p4_dat_i), .wb_ack_i(p4_ack),
        .wb_err_i(1'b0), .wb_rty_i(1'b0)
    );

    // Main slave: zero-wait, status done after a chosen number of reads, one-shot rty, sticky err.
    logic [31:0] status_val = 32'h1;
    int          stat_reads = 0;
    int          stat_done_thresh = 0;
    int          rty_cnt = 0;
    int          rty_limit = 0;
    logic [7:0]  rty_adr = 8'hFF;
    logic        err_en = 1'b0;
    logic [7:0]  err_adr = 8'hFF;

    logic [7:0]  log_adr[$];
    logic        log_we[$];
    logic [31:0] log_dat[$];
    logic [1:0]  log_rsp[$];

    always_comb begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        wb_dat_i = '0;
        if (wb_cyc_o && wb_stb_o) begin
            if (err_en && wb_adr_o == err_adr) wb_err_i = 1'b1;
            else if (rty_cnt < rty_limit && wb_adr_o == rty_adr) wb_rty_i = 1'b1;
            else begin
                wb_ack_i = 1'b1;
                case (wb_adr_o)
                    8'h18: wb_dat_i = (stat_reads + 1 >= stat_done_thresh) ? status_val : 32'h0;
                    8'h1C: wb_dat_i = 32'h41EA3A0A;
                    8'h20: wb_dat_i = 32'h94BAA940;
                    default: wb_dat_i = 32'h0;
                endcase
            end
        end
    end

    always @(posedge clk) begin
        if (wb_cyc_o && wb_stb_o && (wb_ack_i || wb_err_i || wb_rty_i)) begin
            log_adr.push_back(wb_adr_o);
            log_we.push_back(wb_we_o);
            log_dat.push_back(wb_dat_o);
            log_rsp.push_back(wb_err_i ? 2'd1 : (wb_rty_i ? 2'd2 : 2'd0));
            if (wb_rty_i) rty_cnt <= rty_cnt + 1;
            if (wb_ack_i && !wb_we_o && wb_adr_o == 8'h18) stat_reads <= stat_reads + 1;
        end
    end

    // POLL_MAX=4 instance: status always reads 0
    int p4_stat_reads = 0;
    int p4_xfers = 0;
    assign p4_ack   = p4_cyc && p4_stb;
    assign p4_dat_i = 32'h0;
    always @(posedge clk) begin
        if (p4_ack) begin
            p4_xfers <= p4_xfers + 1;
            if (!p4_we && p4_adr == 8'h18) p4_stat_reads <= p4_stat_reads + 1;
        end
    end

    task automatic run_op(input logic md, input logic [127:0] k, input logic [63:0] d,
                          input int done_at, input int glitch_at,
                          output int lat, output bit seen, output logic e,
                          output logic [63:0] r, output logic busy_early, output logic busy_done);
        @(negedge clk);
        log_adr.delete(); log_we.delete(); log_dat.delete(); log_rsp.delete();
        status_val       = md ? 32'h2 : 32'h1;
        stat_done_thresh = stat_reads + done_at;
        mode_i  = md;
        key_i   = k;
        data_i  = d;
        start_i = 1'b1;
        lat = 0; seen = 0; e = 1'bx; r = 'x; busy_early = 1'bx; busy_done = 1'bx;
        while (!seen && lat < 3000) begin
            @(negedge clk);
            lat++;
            start_i = (lat == glitch_at);
            if (lat == 1) busy_early = busy_o;
            if (done_o) begin
                seen = 1; e = err_o; r = result_o; busy_done = busy_o;
            end
        end
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b0; start_i = 1'b0; mode_i = 1'b0; key_i = '0; data_i = '0; p4_start = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (wb_cyc_o !== 1'b0) begin n_fail++; $display("FAIL reset_cyc got %b want 0", wb_cyc_o); end
        n_tests++; if (wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL reset_stb got %b want 0", wb_stb_o); end
        n_tests++; if (wb_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", wb_we_o); end
        n_tests++; if (wb_adr_o !== 8'h00) begin n_fail++; $display("FAIL reset_adr got %h want 00", wb_adr_o); end
        n_tests++; if (wb_dat_o !== 32'h0) begin n_fail++; $display("FAIL reset_dat got %h want 0", wb_dat_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_tests++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_o); end
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_o); end
        n_tests++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result_o); end
        n_tests++; if (wb_sel_o !== 4'hF) begin n_fail++; $display("FAIL sel got %h want F", wb_sel_o); end
        n_tests++; if (wb_cti_o !== 3'b000) begin n_fail++; $display("FAIL cti got %b want 000", wb_cti_o); end
        n_tests++; if (wb_bte_o !== 2'b00) begin n_fail++; $display("FAIL bte got %b want 00", wb_bte_o); end
        n_tests++; if (p4_cyc !== 1'b0) begin n_fail++; $display("FAIL reset_p4_cyc got %b want 0", p4_cyc); end
        wb_rst_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_encrypt();
        logic [7:0] ea [11] = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h00, 8'h04, 8'h18, 8'h18, 8'h18, 8'h1C, 8'h20};
        int lat; bit seen; logic e, be, bd; logic [63:0] r;
        run_op(1'b0, '0, '0, 3, -1, lat, seen, e, r, be, bd);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL enc_done timeout after %0d cycles", lat); end
        n_tests++; if (lat != 24) begin n_fail++; $display("FAIL enc_latency got %0d want 24", lat); end
        n_tests++; if (r !== 64'h94BAA940_41EA3A0A) begin n_fail++; $display("FAIL enc_result got %h want 94BAA94041EA3A0A", r); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL enc_err got %b want 0", e); end
        n_tests++; if (be !== 1'b1) begin n_fail++; $display("FAIL enc_busy_start got %b want 1", be); end
        n_tests++; if (bd !== 1'b0) begin n_fail++; $display("FAIL enc_busy_at_done got %b want 0", bd); end
        n_tests++;
        if (log_adr.size() != 11) begin n_fail++; $display("FAIL enc_xfer_count got %0d want 11", log_adr.size()); end
        else begin
            for (int i = 0; i < 11; i++) begin
                n_tests++;
                if (log_adr[i] !== ea[i] || log_we[i] !== (i < 6) || log_rsp[i] !== 2'd0) begin
                    n_fail++;
                    $display("FAIL enc_xfer%0d got adr=%h we=%b rsp=%0d want adr=%h we=%b rsp=0",
                             i, log_adr[i], log_we[i], log_rsp[i], ea[i], (i < 6));
                end
            end
        end
    endtask

    task automatic test_decrypt();
        logic [7:0]  ea [11] = '{8'h08, 8'h0C, 8'h10, 8'h14, 8'h00, 8'h04, 8'h18, 8'h18, 8'h18, 8'h24, 8'h28};
        int lat; bit seen; logic e, be, bd; logic [63:0] r;
        run_op(1'b1, '0, 64'h94BAA940_41EA3A0A, 3, 5, lat, seen, e, r, be, bd);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL dec_done timeout after %0d cycles", lat); end
        n_tests++; if (lat != 24) begin n_fail++; $display("FAIL dec_latency got %0d want 24", lat); end
        n_tests++; if (r !== 64'h0) begin n_fail++; $display("FAIL dec_result got %h want 0", r); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL dec_err got %b want 0", e); end
        n_tests++;
        if (log_adr.size() != 11) begin n_fail++; $display("FAIL dec_xfer_count got %0d want 11", log_adr.size()); end
        else begin
            for (int i = 0; i < 11; i++) begin
                n_tests++;
                if (log_adr[i] !== ea[i]) begin
                    n_fail++; $display("FAIL dec_adr%0d got %h want %h", i, log_adr[i], ea[i]);
                end
            end
            n_tests++; if (log_dat[4] !== 32'h41EA3A0A) begin n_fail++; $display("FAIL dec_rega got %h want 41EA3A0A", log_dat[4]); end
            n_tests++; if (log_dat[5] !== 32'h94BAA940) begin n_fail++; $display("FAIL dec_regb got %h want 94BAA940", log_dat[5]); end
        end
        repeat (10) @(negedge clk);
        n_tests++; if (log_adr.size() != 11) begin n_fail++; $display("FAIL dec_no_second_op got %0d xfers want 11", log_adr.size()); end
        n_tests++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_fail++; $display("FAIL dec_idle_after got busy=%b done=%b want 0/0", busy_o, done_o); end
    endtask

    task automatic test_retry();
        logic [7:0]  ea [12] = '{8'h08, 8'h0C, 8'h10, 8'h10, 8'h14, 8'h00, 8'h04, 8'h18, 8'h18, 8'h18, 8'h1C, 8'h20};
        logic [31:0] ed [7]  = '{32'h01234567, 32'h89ABCDEF, 32'h76543210, 32'h76543210,
                                 32'hFEDCBA98, 32'hDEADBEEF, 32'hCAFEF00D};
        int lat; bit seen; logic e, be, bd; logic [63:0] r;
        rty_adr = 8'h10; rty_limit = rty_cnt + 1;
        run_op(1'b0, 128'hFEDCBA98_76543210_89ABCDEF_01234567, 64'hCAFEF00D_DEADBEEF, 3, -1,
               lat, seen, e, r, be, bd);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rty_done timeout after %0d cycles", lat); end
        n_tests++; if (lat != 26) begin n_fail++; $display("FAIL rty_latency got %0d want 26", lat); end
        n_tests++; if (r !== 64'h94BAA940_41EA3A0A) begin n_fail++; $display("FAIL rty_result got %h want 94BAA94041EA3A0A", r); end
        n_tests++; if (e !== 1'b0) begin n_fail++; $display("FAIL rty_err got %b want 0", e); end
        n_tests++;
        if (log_adr.size() != 12) begin n_fail++; $display("FAIL rty_xfer_count got %0d want 12", log_adr.size()); end
        else begin
            for (int i = 0; i < 12; i++) begin
                n_tests++;
                if (log_adr[i] !== ea[i] || log_rsp[i] !== ((i == 2) ? 2'd2 : 2'd0) ||
                    (i < 7 && log_dat[i] !== ed[i])) begin
                    n_fail++;
                    $display("FAIL rty_xfer%0d got adr=%h dat=%h rsp=%0d want adr=%h rsp=%0d",
                             i, log_adr[i], log_dat[i], log_rsp[i], ea[i], (i == 2) ? 2 : 0);
                end
            end
        end
    endtask

    task automatic test_error();
        int lat; bit seen; logic e, be, bd; logic [63:0] r;
        err_en = 1'b1; err_adr = 8'h04;
        run_op(1'b0, 128'hFEDCBA98_76543210_89ABCDEF_01234567, 64'hCAFEF00D_DEADBEEF, 3, -1,
               lat, seen, e, r, be, bd);
        err_en = 1'b0;
        n_tests++; if (!seen) begin n_fail++; $display("FAIL err_done timeout after %0d cycles", lat); end
        n_tests++; if (lat != 15) begin n_fail++; $display("FAIL err_latency got %0d want 15", lat); end
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL err_flag got %b want 1", e); end
        n_tests++; if (r !== 64'h94BAA940_41EA3A0A) begin n_fail++; $display("FAIL err_result_kept got %h want 94BAA94041EA3A0A", r); end
        n_tests++; if (log_adr.size() != 6) begin n_fail++; $display("FAIL err_xfer_count got %0d want 6", log_adr.size()); end
        else begin
            n_tests++;
            if (log_adr[5] !== 8'h04 || log_rsp[5] !== 2'd1) begin
                n_fail++; $display("FAIL err_last_xfer got adr=%h rsp=%0d want adr=04 rsp=1", log_adr[5], log_rsp[5]);
            end
        end
        repeat (5) @(negedge clk);
        n_tests++; if (log_adr.size() != 6) begin n_fail++; $display("FAIL err_no_poll got %0d xfers want 6", log_adr.size()); end
    endtask

    task automatic test_poll_timeout();
        int lat = 0; bit seen = 0; logic e = 1'bx;
        int base_reads, base_xfers;
        @(negedge clk);
        base_reads = p4_stat_reads;
        base_xfers = p4_xfers;
        p4_start = 1'b1;
        while (!seen && lat < 3000) begin
            @(negedge clk);
            lat++;
            p4_start = 1'b0;
            if (p4_done) begin seen = 1; e = p4_err; end
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL tmo_done timeout after %0d cycles", lat); end
        n_tests++; if (e !== 1'b1) begin n_fail++; $display("FAIL tmo_err got %b want 1", e); end
        n_tests++; if (lat != 23) begin n_fail++; $display("FAIL tmo_latency got %0d want 23", lat); end
        n_tests++; if (p4_stat_reads - base_reads != 4) begin n_fail++; $display("FAIL tmo_status_reads got %0d want 4", p4_stat_reads - base_reads); end
        n_tests++; if (p4_xfers - base_xfers != 10) begin n_fail++; $display("FAIL tmo_xfers got %0d want 10", p4_xfers - base_xfers); end
    endtask

    task automatic test_reset_midpoll();
        bit found = 0;
        int lat; bit seen; logic e, be, bd; logic [63:0] r;
        @(negedge clk);
        status_val = 32'h1; stat_done_thresh = stat_reads + 100000;
        mode_i = 1'b0; key_i = '0; data_i = '0; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk);
            if (wb_stb_o && wb_adr_o == 8'h18) found = 1;
        end
        n_tests++; if (!found) begin n_fail++; $display("FAIL rst_reach_poll no status strobe seen"); end
        #2 wb_rst_i = 1'b0;
        #1;
        n_tests++; if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_strobe got cyc=%b stb=%b want 0/0", wb_cyc_o, wb_stb_o); end
        n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b want 0", busy_o); end
        n_tests++; if (wb_adr_o !== 8'h00) begin n_fail++; $display("FAIL rst_async_adr got %h want 00", wb_adr_o); end
        n_tests++; if (result_o !== 64'h0) begin n_fail++; $display("FAIL rst_async_result got %h want 0", result_o); end
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b1;
        repeat (4) @(negedge clk);
        run_op(1'b0, '0, '0, 3, -1, lat, seen, e, r, be, bd);
        n_tests++; if (!seen) begin n_fail++; $display("FAIL rst_after_done timeout after %0d cycles", lat); end
        n_tests++; if (lat != 24) begin n_fail++; $display("FAIL rst_after_latency got %0d want 24", lat); end
        n_tests++; if (r !== 64'h94BAA940_41EA3A0A || e !== 1'b0) begin n_fail++; $display("FAIL rst_after_result got %h err=%b want 94BAA94041EA3A0A err=0", r, e); end
        n_tests++; if (log_adr.size() != 11) begin n_fail++; $display("FAIL rst_after_xfers got %0d want 11", log_adr.size()); end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_retry();
        test_error();
        test_poll_timeout();
        test_reset_midpoll();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tea_wb_master.md
TEA_WB_MASTER -- requirements
Module: tea_wb_master

Interface
REQ-001 Parameter ADR_KEY0, default 8'h08, meaning byte address of KEY0; KEY1..KEY3 follow at +4 each.
REQ-002 Parameter ADR_REGA / ADR_REGB, defaults 8'h00 / 8'h04, meaning operand word addresses (v0 / v1).
REQ-003 Parameter ADR_STATUS, default 8'h18, meaning status word address; bit0 = done_enc, bit1 = done_dec.
REQ-004 Parameter ADR_RES_E0 / ADR_RES_D0, defaults 8'h1C / 8'h24, meaning result word 0 address; word 1 is at +4.
REQ-005 Parameter POLL_MAX, default 1024, meaning the maximum number of status reads before timeout.
REQ-006 wb_clk_i  in  1  single clock; wb_rst_i  in  1  asynchronous, active-low reset.
REQ-007 start_i  in  1  launch request; mode_i  in  1  0 = encrypt, 1 = decrypt.
REQ-008 key_i  in  128  key, [31:0] = KEY0; data_i  in  64  operand, [31:0] = v0.
REQ-009 busy_o  out  1  operation in progress; done_o  out  1  one-cycle completion pulse.
REQ-010 result_o  out  64  result, [31:0] = word 0; err_o  out  1  valid with done_o, failure flag.
REQ-011 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic master strobes.
REQ-012 wb_adr_o  out  8; wb_dat_o  out  32; wb_sel_o  out  4; wb_cti_o  out  3; wb_bte_o  out  2.
REQ-013 wb_dat_i  in  32; wb_ack_i, wb_err_i, wb_rty_i  in  1 each.

Function
REQ-014 The module SHALL hold wb_sel_o at 4'hF, wb_cti_o at 3'b000, and wb_bte_o at 2'b00 at all times.
REQ-015 start_i SHALL be accepted only in IDLE; a start_i asserted while busy_o is high SHALL be ignored.
REQ-016 On accept, the module SHALL register key_i, data_i, and mode_i, and busy_o SHALL go high the next cycle.
REQ-017 The FSM states SHALL be IDLE -> WRITE -> POLL -> READ -> DONE -> IDLE, with ERR -> DONE.
REQ-018 WRITE SHALL perform 6 single writes in this order: KEY0, KEY1, KEY2, KEY3, REGA, REGB.
REQ-019 Each transfer SHALL assert cyc/stb (and we for writes) and hold adr and dat stable until ack, err, or rty is sampled high.
REQ-020 After each terminated transfer, cyc/stb SHALL deassert for exactly 1 cycle before the next transfer starts.
REQ-021 On wb_rty_i, the same transfer SHALL be reissued after the 1-cycle gap, with no retry limit.
REQ-022 On wb_err_i in any state, the module SHALL go to ERR, abandon the remaining transfers, and leave result_o unchanged.
REQ-023 POLL SHALL read ADR_STATUS repeatedly and exit to READ when bit[mode] = 1.
REQ-024 POLL SHALL count completed status reads and go to ERR when the count reaches POLL_MAX without the done bit.
REQ-025 READ SHALL read word 0 and then word 1 from RES_E0 (mode 0) or RES_D0 (mode 1) into result_o.
REQ-026 DONE SHALL pulse done_o for 1 cycle, with err_o = 1 only when DONE is entered from ERR.
REQ-027 busy_o SHALL drop in the same cycle that done_o is high.
REQ-028 With a zero-wait slave (ack the cycle after stb), the total latency from start_i to done_o SHALL be 2 x (6 + P + 2) + 2 cycles, where P = number of status reads.
REQ-029 result_o SHALL hold its value until the next successful completion.

Reset
REQ-030 Reset SHALL be asynchronous assert and synchronous deassert, active-low, and SHALL take effect mid-transfer.
REQ-031 Reset values: FSM IDLE; cyc/stb/we/busy/done/err = 0; adr = 0; wb_dat_o = 0; result_o = 0; poll counter = 0.

Structure
REQ-032 A shared package tea_wb_pkg SHALL hold the FSM state enum, the default address constants, and the STATUS bit indices.
REQ-033 A single sub-module wb_single_xfer SHALL implement one classic transfer (req/we/adr/wdat in; ack/err/rty result and rdat out) including the 1-cycle gap.

Verification
REQ-034 The bench SHALL cover each scenario below with a slave BFM.
REQ-035 Encrypt: key = 0, data = 0, mode 0, status done at the 3rd poll, result words 41EA3A0A / 94BAA940 -> 6 writes in order, 3 status reads, reads at 0x1C and 0x20, result_o = 64'h94BAA940_41EA3A0A, err_o = 0, latency 24 cycles.
REQ-036 Decrypt: same key, mode 1 -> reads at 0x24 and 0x28; a start_i pulse issued mid-operation produces no second transaction.
REQ-037 wb_rty_i on the KEY2 write -> KEY2 reissued with the same adr and data; the sequence otherwise unchanged.
REQ-038 wb_err_i on the REGB write -> no poll occurs, done_o = 1 and err_o = 1, result_o keeps its previous value.
REQ-039 Status stuck at 0 with POLL_MAX = 4 -> exactly 4 status reads, then done_o = 1 and err_o = 1.
REQ-040 wb_rst_i low during POLL with stb high -> cyc/stb fall asynchronously; after release, a new start_i completes normally.
